// File: rtl/ysyx_25060173_regwb_arbiter_pkg.sv
// Shared CPU constants: default register-file geometry and writeback requester indices.
package ysyx_25060173_regwb_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic REQ_EXU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25060173_regwb_arbiter_if.sv
// Writeback bus: two requester handshakes (EXU, LSU) and the register-file write port.
interface ysyx_25060173_regwb_arbiter_if #(
  parameter int ADDR_WIDTH = ysyx_25060173_regwb_arbiter_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = ysyx_25060173_regwb_arbiter_pkg::DATA_WIDTH_DEF
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  // Requester side: presents requests, observes grants and the register-file write.
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/ysyx_25060173_regwb_arbiter_scoreboard.sv
// Register busy scoreboard: one pending-write bit per register, x0 never busy.
module ysyx_25060173_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] rd1_idx,
  output logic                  rd1_busy,
  input  logic [ADDR_WIDTH-1:0] rd2_idx,
  output logic                  rd2_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Next busy vector: clear on writeback, set on issue (set wins), flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en && (set_idx != '0)) busy_nxt[set_idx] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Read ports look only at registered state; bit 0 is held at zero so x0 reads idle.
  assign rd1_busy = busy[rd1_idx];
  assign rd2_busy = busy[rd2_idx];

endmodule

// File: rtl/ysyx_25060173_regwb_arbiter.sv
// Round-robin writeback arbiter between EXU and LSU with registered register-file write
// and a busy scoreboard for hazard queries.
module ysyx_25060173_regwb_arbiter
  import ysyx_25060173_regwb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic [ADDR_WIDTH-1:0]          rs1_addr,
  output logic                           rs1_busy,
  input  logic [ADDR_WIDTH-1:0]          rs2_addr,
  output logic                           rs2_busy,
  ysyx_25060173_regwb_arbiter_if.slave   wb
);

  logic                  last_grant;
  logic                  grant;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  // Grant selection: lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant = REQ_EXU;
    if (wb.req0_valid && wb.req1_valid) grant = ~last_grant;
    else if (wb.req1_valid)             grant = REQ_LSU;
  end

  assign wb.req0_ready = wb.req0_valid && (grant == REQ_EXU);
  assign wb.req1_ready = wb.req1_valid && (grant == REQ_LSU);
  assign xfer          = wb.req0_valid || wb.req1_valid;
  assign xfer_addr     = (grant == REQ_LSU) ? wb.req1_addr : wb.req0_addr;
  assign xfer_data     = (grant == REQ_LSU) ? wb.req1_data : wb.req0_data;

  // Round-robin pointer and registered write port; x0 writes are accepted but suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_LSU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (xfer) begin
      last_grant <= grant;
      rf_we_q    <= (xfer_addr != '0);
      rf_waddr_q <= xfer_addr;
      rf_wdata_q <= xfer_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;

  ysyx_25060173_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (issue_valid),
    .set_idx  (issue_rd),
    .clr_en   (xfer && (xfer_addr != '0)),
    .clr_idx  (xfer_addr),
    .rd1_idx  (rs1_addr),
    .rd1_busy (rs1_busy),
    .rd2_idx  (rs2_addr),
    .rd2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_ysyx_25060173_regwb_arbiter.sv
// Directed bench for the writeback arbiter: grant order, write timing, x0 handling,
// scoreboard set/clear/flush and asynchronous reset.
module tb_ysyx_25060173_regwb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] rs1_addr;
  logic          rs1_busy;
  logic [AW-1:0] rs2_addr;
  logic          rs2_busy;

  int nvec;
  int nmis;

  ysyx_25060173_regwb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  ysyx_25060173_regwb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs1_busy    (rs1_busy),
    .rs2_addr    (rs2_addr),
    .rs2_busy    (rs2_busy),
    .wb          (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_reqs();
    wb.req0_valid = 1'b0;
    wb.req1_valid = 1'b0;
    issue_valid   = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    idle_reqs();
    issue_rd = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    wb.req0_addr = '0; wb.req0_data = '0;
    wb.req1_addr = '0; wb.req1_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rs1_addr = 5'd7;
    #1;
    chk("rst_we",    64'(wb.rf_we),    64'd0);
    chk("rst_waddr", 64'(wb.rf_waddr), 64'd0);
    chk("rst_wdata", 64'(wb.rf_wdata), 64'd0);
    chk("rst_busy",  64'(rs1_busy),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single EXU request
    @(negedge clk);
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd5; wb.req0_data = 32'hDEADBEEF;
    #1;
    chk("single_rdy0", 64'(wb.req0_ready), 64'd1);
    chk("single_rdy1", 64'(wb.req1_ready), 64'd0);
    @(negedge clk);
    wb.req0_valid = 1'b0;
    #1;
    chk("single_we",    64'(wb.rf_we),    64'd1);
    chk("single_waddr", 64'(wb.rf_waddr), 64'd5);
    chk("single_wdata", 64'(wb.rf_wdata), 64'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("single_we_drop", 64'(wb.rf_we),    64'd0);
    chk("single_hold_a",  64'(wb.rf_waddr), 64'd5);
    chk("single_hold_d",  64'(wb.rf_wdata), 64'hDEADBEEF);

    // Fresh reset so the EXU wins the first contention
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Round-robin under continuous contention
    wb.req0_addr = 5'd3; wb.req0_data = 32'h3333_0003;
    wb.req1_addr = 5'd4; wb.req1_data = 32'h4444_0004;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        #1;
        chk("rr_we",    64'(wb.rf_we),    64'd1);
        chk("rr_waddr", 64'(wb.rf_waddr), ((k - 1) % 2 == 0) ? 64'd3 : 64'd4);
        chk("rr_wdata", 64'(wb.rf_wdata), ((k - 1) % 2 == 0) ? 64'h3333_0003 : 64'h4444_0004);
      end
      if (k < 4) begin
        wb.req0_valid = 1'b1;
        wb.req1_valid = 1'b1;
        #1;
        chk("rr_rdy0", 64'(wb.req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
        chk("rr_rdy1", 64'(wb.req1_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
      end else begin
        idle_reqs();
      end
    end

    // Issue sets busy (no same-cycle bypass); LSU writeback clears it
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
    #1;
    chk("sb_nobypass", 64'(rs1_busy), 64'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd7; wb.req1_data = 32'h0000_0077;
    #1;
    chk("sb_set7",   64'(rs1_busy),       64'd1);
    chk("sb_rdy1",   64'(wb.req1_ready),  64'd1);
    @(negedge clk);
    wb.req1_valid = 1'b0;
    #1;
    chk("sb_clr7",   64'(rs1_busy),       64'd0);
    chk("sb_lsu_a",  64'(wb.rf_waddr),    64'd7);

    // Same-cycle issue and writeback to 9: set wins
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd9;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd9; wb.req0_data = 32'h99;
    #1;
    chk("sw_rdy0", 64'(wb.req0_ready), 64'd1);
    @(negedge clk);
    idle_reqs();
    #1;
    chk("sw_busy9", 64'(rs2_busy), 64'd1);
    chk("sw_we9",   64'(wb.rf_we), 64'd1);

    // Writeback to x0 is accepted but never written
    @(negedge clk);
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd0; wb.req0_data = 32'h5555;
    #1;
    chk("x0_rdy0", 64'(wb.req0_ready), 64'd1);
    @(negedge clk);
    idle_reqs();
    #1;
    chk("x0_we", 64'(wb.rf_we), 64'd0);

    // Issue to x0 is ignored
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    chk("x0_busy", 64'(rs1_busy), 64'd0);
    chk("sw_busy9_hold", 64'(rs2_busy), 64'd1);

    // Fill the scoreboard, then flush together with an issue
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      issue_valid = 1'b1; issue_rd = AW'(i);
    end
    @(negedge clk);
    rs1_addr = 5'd31; rs2_addr = 5'd1;
    #1;
    chk("fill_busy31", 64'(rs1_busy), 64'd1);
    chk("fill_busy1",  64'(rs2_busy), 64'd1);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd2;
    @(negedge clk);
    idle_reqs();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = AW'(i);
      #1;
      chk("flush_busy", 64'(rs1_busy), 64'd0);
    end

    // Asynchronous reset while a write is on the port
    @(negedge clk);
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd12; wb.req0_data = 32'hCAFE_F00D;
    issue_valid = 1'b1; issue_rd = 5'd13; rs1_addr = 5'd13;
    @(negedge clk);
    idle_reqs();
    #1;
    chk("ar_we_pre",   64'(wb.rf_we),   64'd1);
    chk("ar_busy_pre", 64'(rs1_busy),   64'd1);
    rst = 1'b1;
    #1;
    chk("ar_we",    64'(wb.rf_we),    64'd0);
    chk("ar_waddr", 64'(wb.rf_waddr), 64'd0);
    chk("ar_wdata", 64'(wb.rf_wdata), 64'd0);
    chk("ar_busy",  64'(rs1_busy),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ysyx_25060173_regwb_arbiter.md
YSYX_25060173_REGWB_ARBITER -- requirements
Module: ysyx_25060173_regwb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 Ports SHALL be as follows (one clock; reset is asynchronous and active-high):
  clk          in   1           sole clock, rising edge
  rst          in   1           asynchronous, active-high reset
  flush        in   1           synchronous clear of all scoreboard busy bits
  issue_valid  in   1           an instruction with a destination register is issued
  issue_rd     in   ADDR_WIDTH  destination index of the issued instruction
  rs1_addr     in   ADDR_WIDTH  hazard query index 1
  rs1_busy     out  1           rs1_addr has a pending write
  rs2_addr     in   ADDR_WIDTH  hazard query index 2
  rs2_busy     out  1           rs2_addr has a pending write
  req0_valid   in   1           EXU writeback request
  req0_ready   out  1           EXU request accepted this cycle
  req0_addr    in   ADDR_WIDTH  EXU destination index
  req0_data    in   DATA_WIDTH  EXU result
  req1_valid   in   1           LSU writeback request
  req1_ready   out  1           LSU request accepted this cycle
  req1_addr    in   ADDR_WIDTH  LSU destination index
  req1_data    in   DATA_WIDTH  LSU load data
  rf_we        out  1           register file write enable
  rf_waddr     out  ADDR_WIDTH  register file write index
  rf_wdata     out  DATA_WIDTH  register file write data

Function
REQ-004 Arbitration SHALL be round-robin with a 1-bit last_grant register: if only one reqN_valid is high, that requester is granted; if both are high, the requester other than last_grant is granted.
REQ-005 reqN_ready SHALL be combinational and high only for the granted requester; at most one ready SHALL be high per cycle; ready SHALL NOT depend on any ready.
REQ-006 A transfer SHALL occur when valid && ready; last_grant SHALL update to the granted index only on a transfer.
REQ-007 rf_we/rf_waddr/rf_wdata SHALL be registered: a transfer in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
REQ-008 A transfer with addr == 0 SHALL be accepted (ready high) but SHALL produce rf_we = 0 in cycle N+1.
REQ-009 rf_we SHALL be 0 in any cycle following a cycle with no transfer; rf_waddr/rf_wdata SHALL then hold their previous values.
REQ-010 The scoreboard SHALL be a busy vector of 2^ADDR_WIDTH bits; bit 0 SHALL always read 0.
REQ-011 issue_valid with issue_rd != 0 SHALL set busy[issue_rd] at the next edge; issue_rd == 0 SHALL be ignored.
REQ-012 A transfer to addr != 0 SHALL clear busy[addr] at the next edge.
REQ-013 If issue and transfer target the same nonzero index in the same cycle, set SHALL win (busy remains 1).
REQ-014 flush SHALL clear every busy bit at the next edge and take priority over issue; flush SHALL NOT affect arbitration or the output registers.
REQ-015 rsN_busy SHALL equal busy[rsN_addr] combinationally from registered state (no same-cycle bypass); rsN_addr == 0 SHALL give 0.
REQ-016 Requesters SHALL hold valid, addr and data stable until ready; the block SHALL NOT buffer unaccepted requests.

Reset
REQ-017 While rst is high: rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy vector = all 0, last_grant = 1 (so requester 0 wins the first contention).
REQ-018 Reset asserted mid-operation SHALL drop any registered write (rf_we = 0 immediately, asynchronously); in-flight requests SHALL be re-presented by the requesters after reset.

Structure
REQ-019 ADDR_WIDTH/DATA_WIDTH defaults and the requester index constants (REQ_EXU = 0, REQ_LSU = 1) SHALL live in the shared CPU package.
REQ-020 The scoreboard SHALL be one sub-module, ysyx_25060173_scoreboard (busy vector, set/clear/flush, two read ports); arbitration and the output registers SHALL remain in the top module.

Verification
REQ-021 Reset, then req0 only (addr 5, data 0xDEADBEEF) -> req0_ready = 1 in the same cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; rf_we = 0 in the following cycle.
REQ-022 Both valid for 4 cycles (req0 addr 3, req1 addr 4) -> grants req0, req1, req0, req1; rf_waddr sequence 3, 4, 3, 4.
REQ-023 issue rd 7, then rs1_addr = 7 -> rs1_busy = 1; req1 transfer to 7 -> rs1_busy = 0 one cycle after the transfer.
REQ-024 Same cycle: issue rd 9 and req0 transfer to 9 -> busy[9] = 1 afterwards; req0 to addr 0 -> ready = 1, rf_we stays 0; issue rd 0 -> rs1_busy(0) = 0.
REQ-025 Set busy 1..31, assert flush together with issue rd 2 -> all busy bits 0; assert rst asynchronously while rf_we = 1 -> rf_we = 0 before the next clock edge, and busy = 0.
